// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - ALU to divider request/result bundle
interface div_iter_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  // ALU side: issues the operation, consumes the result
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - radix-2 restoring divider, one quotient bit per cycle
module div_iter import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic        clk,
  input logic        rst,
  div_iter_if.slave  bus
);

  localparam logic [1:0] S_FREE    = FREE;
  localparam logic [1:0] S_BY_ZERO = BY_ZERO;
  localparam logic [1:0] S_ON      = ON;
  localparam logic [1:0] S_END     = END;
  localparam int         CW        = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // remainder is always below the divisor, so its top working bit is implicit zero
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // operand magnitudes at latch time; unsigned mode never sees a negative flag
  always_comb begin
    a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    mag_a = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    mag_b = b_neg ? -bus.opdata2_i : bus.opdata2_i;
  end

  // one shift/trial-subtract step plus the sign-corrected final values
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
    q_fix = neg_q ? -quo_nxt : quo_nxt;
    r_fix = neg_r ? -rem_nxt : rem_nxt;
  end

  // control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_FREE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        S_FREE: begin
          if (bus.start_i == DivStart && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= S_BY_ZERO;
            end else begin
              state   <= S_ON;
              cnt     <= '0;
              rem     <= '0;
              quo     <= mag_a;
              divisor <= mag_b;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
            end
          end
        end
        S_BY_ZERO: begin
          if (bus.annul_i) begin
            state <= S_FREE;
          end else begin
            state        <= S_END;
            bus.result_o <= '0;
            bus.ready_o  <= DivResultReady;
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            state <= S_FREE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state        <= S_END;
              bus.result_o <= {r_fix, q_fix};
              bus.ready_o  <= DivResultReady;
            end
          end
        end
        S_END: begin
          if (bus.start_i == DivStop) begin
            state       <= S_FREE;
            bus.ready_o <= DivResultNotReady;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider for the execute stage. It takes the operands and the start and signedness controls from the ALU, and returns a 64-bit {remainder, quotient} result for the HI/LO path. It runs one quotient bit per cycle over 32 cycles. The ALU holds its stall request while `ready_o` is low.

## Interface
Parameters:
- `WIDTH`, 32, operand width; result is `2*WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low (asserted when 0)
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- `opdata1_i`  in  WIDTH  dividend; sampled with start
- `opdata2_i`  in  WIDTH  divisor; sampled with start
- `start_i`  in  1  request; the ALU holds it high until `ready_o`
- `annul_i`  in  1  abort in-flight division (flush/exception)
- `result_o`  out  2*WIDTH  {remainder[63:32], quotient[31:0]}
- `ready_o`  out  1  result valid

## Operation
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - `start_i=1`, `annul_i=0`, divisor≠0: latch operands, go to ON, clear `cnt`.
  - Divisor = 0: go to BY_ZERO.
  - Otherwise stay in FREE.
- Signed mode: operands are converted to magnitudes at latch time. The sign flags `neg_q = a[31]^b[31]` and `neg_r = a[31]` are stored with them.
- ON, one step per cycle:
  - Working register `{rem[WIDTH:0], quo[WIDTH-1:0]}` shifts left 1.
  - `diff = rem - {1'b0, divisor}`.
  - If `diff` is non-negative, `rem` ← `diff` and the new quotient LSB is 1; otherwise `rem` is kept and the LSB is 0.
  - `cnt` increments.
  - When `cnt == WIDTH-1` completes, go to END.
- END:
  - Apply sign fixes: negate the quotient if `neg_q`; negate the remainder if `neg_r`. Unsigned mode applies no fixes.
  - Drive `result_o` and `ready_o=1`.
  - Stay while `start_i=1`; return to FREE when `start_i=0`.
- BY_ZERO: next cycle goes to END with result `64'h0`.
- Annul: `annul_i=1` in ON or BY_ZERO returns to FREE next cycle; `ready_o` never asserts for that operation. `annul_i` in FREE blocks acceptance.
- Overflow: signed `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000`, remainder 0 (two's-complement wrap). No exception is raised.
- Operand changes after latch are ignored.

## Timing
- Reset (`rst=0` at an edge): state FREE, `cnt=0`, `result_o=0`, `ready_o=0`. Reset mid-ON abandons the operation with no ready pulse.
- Start sampled at edge k:
  - Normal: ON at k+1..k+32, END at k+33; `ready_o` is high from k+33.
  - Divide-by-zero: BY_ZERO at k+1, END at k+2.
- `ready_o` and `result_o` are registered; no combinational path from inputs to outputs.
- Minimum pulse is one cycle, because the ALU drops `start_i` combinationally on `ready_o`.
- `result_o` holds its last value in FREE until the next END.
- Back-to-back: a new start is accepted on the first FREE cycle, giving one bubble after END.

## Structure
- Shared package `div_pkg`:
  - State enum `div_state_t` {FREE, BY_ZERO, ON, END}.
  - Constants `DivStart`/`DivStop` (1/0), `DivResultReady`/`DivResultNotReady`, `DIV_WIDTH=32`.
- Single module; no sub-module required.
- The subtract/shift step may be a function in `div_pkg` for bench reuse.

## Test plan
- Unsigned `100 / 7`, start held until ready → at k+33 `result_o = {32'd2, 32'd14}`, `ready_o=1`; FREE one cycle after `start_i` drops.
- Signed `-7 / 2` (`0xFFFFFFF9`, 2) → quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`. Signed `7 / -2` → quotient `0xFFFFFFFD`, remainder `0x00000001`.
- Divisor 0, any dividend → `ready_o` at k+2, `result_o = 64'h0`.
- `annul_i` pulsed at cycle k+10 → FREE at k+11, `ready_o` stays 0 through k+40; a new `15 / 4` then completes with `{3, 3}`.
- `rst=0` at k+5 mid-ON → outputs 0 and state FREE next cycle. Signed `0x80000000 / 0xFFFFFFFF` → `{0, 0x80000000}`.
- Operands changed every cycle during ON → result matches the values latched at start. `start_i` held 3 cycles after ready → `ready_o` held 3 cycles with a stable result.
